// File: rtl/key_lut_ctrl.sv
// key_lut_ctrl: programmable key->data table feeding the key-select mux.
// Run-time insert/update, registered lookups, and a sweep FSM for clearing.
module key_lut_ctrl #(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 3,
  parameter int DATA_LEN = 4,
  localparam int CW = $clog2(NR_KEY + 1),
  localparam int P  = KEY_LEN + DATA_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  output logic                  busy,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [KEY_LEN-1:0]    wr_key,
  input  logic [DATA_LEN-1:0]   wr_data,
  output logic                  wr_err,
  input  logic                  lk_valid,
  output logic                  lk_ready,
  input  logic [KEY_LEN-1:0]    lk_key,
  output logic                  rsp_valid,
  output logic                  rsp_hit,
  output logic [DATA_LEN-1:0]   rsp_data,
  output logic [CW-1:0]         count,
  output logic [NR_KEY*P-1:0]   lut
);

  localparam int IW = $clog2(NR_KEY);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t              state;
  logic [IW-1:0]       idx;
  logic [NR_KEY-1:0]   vld;
  logic [KEY_LEN-1:0]  keys  [NR_KEY];
  logic [DATA_LEN-1:0] datas [NR_KEY];

  logic                wr_fire;
  logic                lk_fire;
  logic [NR_KEY-1:0]   wr_hit;
  logic [NR_KEY-1:0]   lk_hit;
  logic [NR_KEY-1:0]   free_sel;
  logic [DATA_LEN-1:0] lk_data;

  assign busy     = (state == CLEAR);
  assign wr_ready = (state == RUN) && !clr;
  assign lk_ready = (state == RUN) && !clr;
  assign wr_fire  = wr_valid && wr_ready;
  assign lk_fire  = lk_valid && lk_ready;

  // one-hot of the lowest clear bit; zero when every entry is valid
  assign free_sel = ~vld & (vld + NR_KEY'(1));

  always_comb begin
    wr_hit  = '0;
    lk_hit  = '0;
    lk_data = '0;
    for (int n = 0; n < NR_KEY; n++) begin
      wr_hit[n] = vld[n] && (keys[n] == wr_key);
      lk_hit[n] = vld[n] && (keys[n] == lk_key);
      if (lk_hit[n]) lk_data = lk_data | datas[n];
    end
  end

  // invalid entries expose zero data so an OR-mux never sees stale values
  for (genvar g = 0; g < NR_KEY; g++) begin : g_lut
    assign lut[g*P +: P] = {keys[g], vld[g] ? datas[g] : '0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      idx       <= '0;
      vld       <= '0;
      count     <= '0;
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_data  <= '0;
      wr_err    <= 1'b0;
      for (int n = 0; n < NR_KEY; n++) begin
        keys[n]  <= '0;
        datas[n] <= '0;
      end
    end else begin
      rsp_valid <= lk_fire;
      wr_err    <= 1'b0;
      if (lk_fire) begin
        rsp_hit  <= |lk_hit;
        rsp_data <= lk_data;
      end
      unique case (state)
        CLEAR: begin
          if (clr) begin
            idx <= '0;
          end else begin
            vld[idx]   <= 1'b0;
            keys[idx]  <= '0;
            datas[idx] <= '0;
            if (idx == IW'(NR_KEY - 1)) begin
              idx   <= '0;
              state <= RUN;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        RUN: begin
          if (clr) begin
            state <= CLEAR;
            idx   <= '0;
            count <= '0;
          end else if (wr_fire) begin
            if (|wr_hit) begin
              for (int n = 0; n < NR_KEY; n++)
                if (wr_hit[n]) datas[n] <= wr_data;
            end else if (|free_sel) begin
              for (int n = 0; n < NR_KEY; n++) begin
                if (free_sel[n]) begin
                  vld[n]   <= 1'b1;
                  keys[n]  <= wr_key;
                  datas[n] <= wr_data;
                end
              end
              count <= count + CW'(1);
            end else begin
              wr_err <= 1'b1;
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_key_lut_ctrl.sv
// tb_key_lut_ctrl: scoreboard bench for key_lut_ctrl.
// Directed plan followed by random writes/lookups/clears against a slot model.
module tb_key_lut_ctrl;

  localparam int NK = 4;
  localparam int KL = 3;
  localparam int DL = 4;
  localparam int P  = KL + DL;

  logic          clk;
  logic          rst;
  logic          clr;
  logic          busy;
  logic          wr_valid;
  logic          wr_ready;
  logic [KL-1:0] wr_key;
  logic [DL-1:0] wr_data;
  logic          wr_err;
  logic          lk_valid;
  logic          lk_ready;
  logic [KL-1:0] lk_key;
  logic          rsp_valid;
  logic          rsp_hit;
  logic [DL-1:0] rsp_data;
  logic [2:0]    count;
  logic [NK*P-1:0] lut;

  key_lut_ctrl #(
    .NR_KEY(NK),
    .KEY_LEN(KL),
    .DATA_LEN(DL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .busy(busy),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_key(wr_key),
    .wr_data(wr_data),
    .wr_err(wr_err),
    .lk_valid(lk_valid),
    .lk_ready(lk_ready),
    .lk_key(lk_key),
    .rsp_valid(rsp_valid),
    .rsp_hit(rsp_hit),
    .rsp_data(rsp_data),
    .count(count),
    .lut(lut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic          hit;
    logic [DL-1:0] data;
  } rsp_t;

  rsp_t q[$];

  bit            m_valid [NK];
  logic [KL-1:0] m_key   [NK];
  logic [DL-1:0] m_data  [NK];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic m_clear();
    for (int i = 0; i < NK; i++) begin
      m_valid[i] = 1'b0;
      m_key[i]   = '0;
      m_data[i]  = '0;
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NK; i++) if (m_valid[i]) c++;
    return c;
  endfunction

  function automatic logic [NK*P-1:0] m_lut();
    logic [NK*P-1:0] v = '0;
    for (int i = 0; i < NK; i++)
      v[i*P +: P] = {m_key[i], m_valid[i] ? m_data[i] : 4'h0};
    return v;
  endfunction

  task automatic m_lookup(input logic [KL-1:0] k,
                          output bit hit,
                          output logic [DL-1:0] d);
    hit = 1'b0;
    d   = '0;
    for (int i = 0; i < NK; i++)
      if (m_valid[i] && m_key[i] == k) begin
        hit = 1'b1;
        d   = m_data[i];
      end
  endtask

  task automatic m_write(input logic [KL-1:0] k,
                         input logic [DL-1:0] d,
                         output bit err);
    int slot = -1;
    err = 1'b0;
    for (int i = 0; i < NK; i++)
      if (m_valid[i] && m_key[i] == k) slot = i;
    if (slot >= 0) begin
      m_data[slot] = d;
    end else begin
      for (int i = NK - 1; i >= 0; i--)
        if (!m_valid[i]) slot = i;
      if (slot < 0) begin
        err = 1'b1;
      end else begin
        m_valid[slot] = 1'b1;
        m_key[slot]   = k;
        m_data[slot]  = d;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input bit wv,
                    input logic [KL-1:0] wk,
                    input logic [DL-1:0] wd,
                    input bit lv,
                    input logic [KL-1:0] lk);
    bit            eh;
    logic [DL-1:0] ed;
    bit            eerr;
    wr_valid = wv;
    wr_key   = wk;
    wr_data  = wd;
    lk_valid = lv;
    lk_key   = lk;
    #1;
    check("wr_ready", {wr_ready, lk_ready}, 2'b11);
    eh = 1'b0;
    ed = '0;
    eerr = 1'b0;
    if (lv) m_lookup(lk, eh, ed);
    if (wv) m_write(wk, wd, eerr);
    step();
    wr_valid = 1'b0;
    lk_valid = 1'b0;
    if (lv) q.push_back({eh, ed});
    check("wr_err", wr_err, eerr);
    check("count", count, m_count());
    check("lut", lut, m_lut());
  endtask

  task automatic expect_busy(input int n);
    for (int i = 0; i < n; i++) begin
      check("sweep_busy", {busy, wr_ready, lk_ready}, 3'b100);
      step();
    end
    check("sweep_done", {busy, wr_ready, lk_ready}, 3'b011);
    check("sweep_lut", lut, m_lut());
    check("sweep_count", count, 0);
  endtask

  task automatic do_clear();
    clr = 1'b1;
    step();
    clr = 1'b0;
    m_clear();
    expect_busy(NK);
  endtask

  logic          last_hit = 1'b0;
  logic [DL-1:0] last_data = '0;

  always @(negedge clk) begin
    rsp_t e;
    if (rst) begin
      last_hit  = 1'b0;
      last_data = '0;
    end else begin
      check("rsp_valid", rsp_valid, q.size() != 0);
      if (q.size() != 0) begin
        e = q.pop_front();
        if (rsp_valid) begin
          check("rsp_hit", rsp_hit, e.hit);
          check("rsp_data", rsp_data, e.data);
        end
      end else if (!rsp_valid) begin
        check("rsp_hold", {rsp_hit, rsp_data}, {last_hit, last_data});
      end
      if (rsp_valid) begin
        last_hit  = rsp_hit;
        last_data = rsp_data;
      end
    end
  end

  initial begin
    rst      = 1'b1;
    clr      = 1'b0;
    wr_valid = 1'b0;
    wr_key   = '0;
    wr_data  = '0;
    lk_valid = 1'b0;
    lk_key   = '0;
    m_clear();

    repeat (2) step();
    rst = 1'b0;
    expect_busy(NK);

    op(1, 3'd1, 4'hA, 0, 3'd0);
    op(1, 3'd5, 4'h3, 0, 3'd0);
    check("count_two", count, 3'd2);
    check("pair0", lut[6:0], 7'h1A);
    check("pair1", lut[13:7], 7'h53);
    op(0, 3'd0, 4'h0, 1, 3'd5);
    op(0, 3'd0, 4'h0, 1, 3'd2);

    op(1, 3'd5, 4'hC, 0, 3'd0);
    check("count_upd", count, 3'd2);
    op(0, 3'd0, 4'h0, 1, 3'd5);
    op(1, 3'd6, 4'h2, 0, 3'd0);
    op(1, 3'd7, 4'h1, 0, 3'd0);
    check("count_full", count, 3'd4);
    op(1, 3'd0, 4'hF, 0, 3'd0);
    check("err_pulse", wr_err, 1'b1);
    step();
    check("err_drop", wr_err, 1'b0);
    check("full_lut", lut, m_lut());

    op(1, 3'd6, 4'h9, 1, 3'd6);
    op(0, 3'd0, 4'h0, 1, 3'd6);

    clr      = 1'b1;
    wr_valid = 1'b1;
    wr_key   = 3'd3;
    wr_data  = 4'h4;
    #1;
    check("clr_blocks", {wr_ready, lk_ready}, 2'b00);
    step();
    clr      = 1'b0;
    wr_valid = 1'b0;
    m_clear();
    expect_busy(NK);

    clr = 1'b1;
    step();
    clr = 1'b0;
    check("sweep1", busy, 1'b1);
    step();
    check("sweep2", busy, 1'b1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    expect_busy(NK);
    op(0, 3'd0, 4'h0, 1, 3'd1);

    op(1, 3'd2, 4'h7, 0, 3'd0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_clear();
    expect_busy(NK);

    repeat (300) begin
      if ($urandom_range(0, 39) == 0) begin
        do_clear();
      end else begin
        op(1'($urandom), 3'($urandom), 4'($urandom),
           1'($urandom), 3'($urandom));
      end
    end

    repeat (3) step();
    check("rsp_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/key_lut_ctrl.md
Name: key_lut_ctrl

Overview:
- Owns a programmable key→data table of NR_KEY entries.
- Drives the flattened {key,data} lut bus consumed by the key-select mux datapath, so the table can be configured at run time.
- Also serves registered lookups with a hit flag.
- Sits between a config/CPU-side writer and the mux consumers; a sweep FSM handles table clearing.

Parameters:
- NR_KEY, 4, number of table entries (≥2)
- KEY_LEN, 3, key width in bits
- DATA_LEN, 4, data width in bits
- CW, $clog2(NR_KEY+1), width of the occupancy count (localparam)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- clr  input  1  single-cycle request to invalidate the whole table
- busy  output  1  high while the clear sweep runs
- wr_valid  input  1  write request
- wr_ready  output  1  write may be accepted this cycle
- wr_key  input  KEY_LEN  key to insert or update
- wr_data  input  DATA_LEN  data for that key
- wr_err  output  1  one-cycle pulse: last accepted write rejected (table full)
- lk_valid  input  1  lookup request
- lk_ready  output  1  lookup may be accepted this cycle
- lk_key  input  KEY_LEN  key to look up
- rsp_valid  output  1  one-cycle lookup response strobe
- rsp_hit  output  1  key was present
- rsp_data  output  DATA_LEN  matched data, 0 on miss
- count  output  CW  number of valid entries
- lut  output  NR_KEY*(KEY_LEN+DATA_LEN)  pair n at bits [(n+1)*P-1 : n*P], P = KEY_LEN+DATA_LEN; key in the upper KEY_LEN bits, data in the lower bits

Behaviour:
- Clock and reset: single clock domain (clk); synchronous active-high reset (rst).
- Per-entry storage: valid bit, key, data.
- lut bus contents:
  - Valid entry: pair is {key, data}.
  - Invalid entry: pair is {stored key, DATA_LEN'b0}. Data must be zero so an OR-reduction mux never picks up stale data.
- FSM states: CLEAR, RUN.
- Reset (rst=1 at an edge):
  - state=CLEAR, sweep idx=0.
  - All valid bits=0, count=0, rsp_valid=0, rsp_hit=0, rsp_data=0, wr_err=0.
  - All stored keys and data=0, so lut=0.
  - rst overrides every other input, including mid-write and mid-sweep.
- CLEAR state:
  - Each cycle zeroes entry idx (valid, key, data) and increments idx.
  - After idx=NR_KEY-1 is cleared, go to RUN. The sweep takes exactly NR_KEY cycles.
  - busy=1; wr_ready=lk_ready=0.
  - clr during CLEAR restarts the sweep at idx=0.
- RUN state:
  - busy=0; wr_ready = lk_ready = !clr (combinational).
  - clr=1 → go to CLEAR next cycle with idx=0, count=0. Any valid/request that cycle is not handshaken.
- Write (wr_valid & wr_ready):
  - If a valid entry's key equals wr_key, replace its data. count is unchanged.
  - Else allocate the lowest-index invalid entry, set it valid, count+1.
  - Else (table full, no match): table unchanged; wr_err=1 for the next cycle only.
  - Table update is visible on lut and to lookups from the next cycle on.
- Lookup (lk_valid & lk_ready):
  - Compare lk_key against valid entries only.
  - Response is registered, latency 1: next cycle rsp_valid=1, rsp_hit=match, rsp_data = matched data or 0.
  - No backpressure on responses. rsp_valid is low in every cycle not following an accepted lookup.
  - rsp_hit and rsp_data hold their last values while rsp_valid=0.
- Same-cycle write and lookup: both accepted; the lookup sees the pre-write table.
- Keys are unique by construction; no priority encoding is needed on lookup.
- count never exceeds NR_KEY; no wrap.

Test Plan (NR_KEY=4, KEY_LEN=3, DATA_LEN=4):
- Reset and sweep: rst high 2 cycles, then low → busy=1 and wr_ready=lk_ready=0 for exactly 4 cycles, then busy=0, wr_ready=1; lut=0, count=0.
- Insert and look up: write (1,0xA), (5,0x3) → count=2; lut[6:0]=0x1A, lut[13:7]=0x53. Lookup key 5 → next cycle rsp_valid=1, rsp_hit=1, rsp_data=0x3. Lookup key 2 → rsp_hit=0, rsp_data=0.
- Update and overflow: write (5,0xC) → count stays 2, lookup 5 returns 0xC. Fill keys 6,7 → count=4. Write (0,0xF) → wr_err pulses for 1 cycle, table unchanged.
- Simultaneous write and lookup: write (6,0x9) over stored 0x2 while looking up key 6 in the same cycle → response data=0x2; a lookup next cycle returns 0x9.
- Clear mid-operation: clr in RUN with wr_valid high → write not accepted, 4-cycle sweep, count=0. A second clr on sweep cycle 2 → busy lasts 2+4 cycles total. After the sweep, lookup of 1 misses.
- Reset mid-sweep: rst during CLEAR → sweep restarts from idx 0, full 4 cycles after rst falls.
